// File: rtl/uart_cal_parser.sv
// rtl/uart_cal_parser.sv - ASCII "<operand><op><operand><terminator>" parser feeding the calculator ALU
// Turns received UART bytes into signed operands, an operator one-hot and status flags.
module uart_cal_parser #(
   parameter int MAX_DIGITS = 5
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   input  logic        alu_done,
   output logic [3:0]  dtype,
   output logic [4:0]  operator,
   output logic [15:0] src1,
   output logic [15:0] src2,
   output logic        parser_done,
   output logic        busy
);

   localparam int CW = $clog2(MAX_DIGITS + 2);

   typedef enum logic [2:0] {
      S_IDLE, S_OP1, S_OP2_START, S_OP2, S_ERR, S_EMIT, S_WAIT_ALU
   } state_t;

   typedef enum logic [1:0] {K_ADD, K_SUB, K_MUL, K_DIV} opk_t;

   state_t        state_q, state_d;
   opk_t          opk_q, opk_d;
   logic          neg1_q, neg1_d, neg2_q, neg2_d, syn_q, syn_d;
   logic [16:0]   mag1_q, mag1_d, mag2_q, mag2_d;
   logic [CW-1:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;
   logic [3:0]    dtype_q, dtype_d;
   logic [4:0]    operator_q, operator_d;
   logic [15:0]   src1_q, src1_d, src2_q, src2_d;

   logic       is_digit, is_term, is_space, is_minus, is_op, err, load, ovf, bad;
   logic [3:0] digit;
   opk_t       opk_rx;

   function automatic logic [16:0] acc10(input logic [16:0] m, input logic [3:0] d);
      logic [20:0] s;
      s = ({4'd0, m} << 3) + ({4'd0, m} << 1) + {17'd0, d};
      return (s > 21'h1FFFF) ? 17'h1FFFF : s[16:0];
   endfunction

   function automatic logic [CW-1:0] cnt_inc(input logic [CW-1:0] c);
      return (c == CW'(MAX_DIGITS + 1)) ? c : c + 1'b1;
   endfunction

   always_comb begin
      is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
      digit    = rx_data[3:0];
      is_term  = (rx_data == 8'h3D) || (rx_data == 8'h0D);
      is_space = (rx_data == 8'h20);
      is_minus = (rx_data == 8'h2D);
      is_op    = 1'b1;
      opk_rx   = K_ADD;
      case (rx_data)
         8'h2B:   opk_rx = K_ADD;
         8'h2D:   opk_rx = K_SUB;
         8'h2A:   opk_rx = K_MUL;
         8'h2F:   opk_rx = K_DIV;
         default: is_op = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      opk_d   = opk_q;
      neg1_d  = neg1_q;
      neg2_d  = neg2_q;
      syn_d   = syn_q;
      mag1_d  = mag1_q;
      mag2_d  = mag2_q;
      cnt1_d  = cnt1_q;
      cnt2_d  = cnt2_q;
      err     = 1'b0;
      load    = 1'b0;
      case (state_q)
         S_IDLE: if (rx_valid && !is_space) begin
            if (is_minus) begin
               neg1_d  = 1'b1;
               state_d = S_OP1;
            end else if (is_digit) begin
               mag1_d  = {13'd0, digit};
               cnt1_d  = CW'(1);
               state_d = S_OP1;
            end else if (!is_term) begin
               err = 1'b1;
            end
         end
         S_OP1: if (rx_valid && !is_space) begin
            if (is_digit) begin
               mag1_d = acc10(mag1_q, digit);
               cnt1_d = cnt_inc(cnt1_q);
            end else if (is_op && cnt1_q != '0) begin
               opk_d   = opk_rx;
               state_d = S_OP2_START;
            end else begin
               err = 1'b1;
            end
         end
         S_OP2_START: if (rx_valid && !is_space) begin
            if (is_minus && !neg2_q) begin
               neg2_d = 1'b1;
            end else if (is_digit) begin
               mag2_d  = {13'd0, digit};
               cnt2_d  = CW'(1);
               state_d = S_OP2;
            end else begin
               err = 1'b1;
            end
         end
         S_OP2: if (rx_valid && !is_space) begin
            if (is_digit) begin
               mag2_d = acc10(mag2_q, digit);
               cnt2_d = cnt_inc(cnt2_q);
            end else if (is_term) begin
               load    = 1'b1;
               state_d = S_EMIT;
            end else begin
               err = 1'b1;
            end
         end
         S_ERR: if (rx_valid && is_term) begin
            load    = 1'b1;
            state_d = S_EMIT;
         end
         S_EMIT: begin
            state_d = (dtype_q[3:2] == 2'b00) ? S_WAIT_ALU : S_IDLE;
            neg1_d  = 1'b0;
            neg2_d  = 1'b0;
            syn_d   = 1'b0;
            mag1_d  = '0;
            mag2_d  = '0;
            cnt1_d  = '0;
            cnt2_d  = '0;
            opk_d   = K_ADD;
         end
         S_WAIT_ALU: if (alu_done) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // A bad terminator ends the expression at once instead of parking in ERR.
      if (err) begin
         syn_d = 1'b1;
         if (is_term) begin
            load    = 1'b1;
            state_d = S_EMIT;
         end else begin
            state_d = S_ERR;
         end
      end
   end

   always_comb begin
      ovf = (cnt1_q > CW'(MAX_DIGITS)) || (cnt2_q > CW'(MAX_DIGITS))
         || (neg1_q ? (mag1_q > 17'd32768) : (mag1_q > 17'd32767))
         || (neg2_q ? (mag2_q > 17'd32768) : (mag2_q > 17'd32767));
      bad        = ovf || syn_d;
      dtype_d    = dtype_q;
      operator_d = operator_q;
      src1_d     = src1_q;
      src2_d     = src2_q;
      if (load) begin
         dtype_d    = {syn_d, ovf, neg2_q, neg1_q};
         operator_d = '0;
         src1_d     = '0;
         src2_d     = '0;
         if (!bad) begin
            src1_d = neg1_q ? (16'd0 - mag1_q[15:0]) : mag1_q[15:0];
            src2_d = neg2_q ? (16'd0 - mag2_q[15:0]) : mag2_q[15:0];
            case (opk_q)
               K_ADD:   operator_d = 5'b00001;
               K_SUB:   operator_d = 5'b00010;
               K_MUL:   operator_d = (neg1_q || neg2_q) ? 5'b01000 : 5'b00100;
               default: operator_d = 5'b10000;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q    <= S_IDLE;
         opk_q      <= K_ADD;
         neg1_q     <= 1'b0;
         neg2_q     <= 1'b0;
         syn_q      <= 1'b0;
         mag1_q     <= '0;
         mag2_q     <= '0;
         cnt1_q     <= '0;
         cnt2_q     <= '0;
         dtype_q    <= '0;
         operator_q <= '0;
         src1_q     <= '0;
         src2_q     <= '0;
      end else begin
         state_q    <= state_d;
         opk_q      <= opk_d;
         neg1_q     <= neg1_d;
         neg2_q     <= neg2_d;
         syn_q      <= syn_d;
         mag1_q     <= mag1_d;
         mag2_q     <= mag2_d;
         cnt1_q     <= cnt1_d;
         cnt2_q     <= cnt2_d;
         dtype_q    <= dtype_d;
         operator_q <= operator_d;
         src1_q     <= src1_d;
         src2_q     <= src2_d;
      end
   end

   assign dtype       = dtype_q;
   assign operator    = operator_q;
   assign src1        = src1_q;
   assign src2        = src2_q;
   assign parser_done = (state_q == S_EMIT);
   assign busy        = (state_q == S_WAIT_ALU);

endmodule

// File: tb/tb_uart_cal_parser.sv
// tb/tb_uart_cal_parser.sv - directed vector bench for uart_cal_parser
module tb_uart_cal_parser;

   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        alu_done = 1'b0;
   logic [3:0]  dtype;
   logic [4:0]  operator;
   logic [15:0] src1, src2;
   logic        parser_done, busy;

   uart_cal_parser #(.MAX_DIGITS(5)) dut (
      .clk(clk), .n_rst(n_rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .alu_done(alu_done), .dtype(dtype), .operator(operator),
      .src1(src1), .src2(src2), .parser_done(parser_done), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [95:0] text;
      logic [3:0]  dtype;
      logic [4:0]  op;
      logic [15:0] s1;
      logic [15:0] s2;
      logic        busy;
   } vec_t;

   localparam int NV = 20;
   vec_t vecs [NV];

   int n_cmp = 0;
   int n_fail = 0;
   int pulse_cnt = 0;
   int dbl_cnt = 0;
   logic pd_prev = 1'b0;

   always @(negedge clk) begin
      if (parser_done) pulse_cnt <= pulse_cnt + 1;
      if (parser_done && pd_prev) dbl_cnt <= dbl_cnt + 1;
      pd_prev <= parser_done;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic send_text(input logic [95:0] t);
      for (int i = 11; i >= 0; i--) begin
         if (t[i*8 +: 8] != 8'h00) send_byte(t[i*8 +: 8], 3);
      end
   endtask

   task automatic pulse_alu_done();
      @(negedge clk);
      alu_done = 1'b1;
      @(negedge clk);
      alu_done = 1'b0;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int p0;
      p0 = pulse_cnt;
      send_text(v.text);
      repeat (2) @(negedge clk);
      chk($sformatf("v%0d pulses", idx), 32'(pulse_cnt - p0), 32'd1);
      chk($sformatf("v%0d dtype", idx), 32'(dtype), 32'(v.dtype));
      chk($sformatf("v%0d operator", idx), 32'(operator), 32'(v.op));
      chk($sformatf("v%0d src1", idx), 32'(src1), 32'(v.s1));
      chk($sformatf("v%0d src2", idx), 32'(src2), 32'(v.s2));
      chk($sformatf("v%0d busy", idx), 32'(busy), 32'(v.busy));
      if (v.busy) begin
         pulse_alu_done();
         chk($sformatf("v%0d busy_clear", idx), 32'(busy), 32'd0);
      end
   endtask

   initial begin
      int p0;
      vecs[0]  = '{"-7 * 3=",   4'b0001, 5'b01000, 16'hFFF9, 16'h0003, 1'b1};
      vecs[1]  = '{"6*3=",      4'b0000, 5'b00100, 16'h0006, 16'h0003, 1'b1};
      vecs[2]  = '{"-32768/2=", 4'b0001, 5'b10000, 16'h8000, 16'h0002, 1'b1};
      vecs[3]  = '{"40000+1=",  4'b0100, 5'b00000, 16'h0000, 16'h0000, 1'b0};
      vecs[4]  = '{"123456+1=", 4'b0100, 5'b00000, 16'h0000, 16'h0000, 1'b0};
      vecs[5]  = '{"12+x3=",    4'b1000, 5'b00000, 16'h0000, 16'h0000, 1'b0};
      vecs[6]  = '{"+5=",       4'b1000, 5'b00000, 16'h0000, 16'h0000, 1'b0};
      vecs[7]  = '{"5+=",       4'b1000, 5'b00000, 16'h0000, 16'h0000, 1'b0};
      vecs[8]  = '{"1-1=",      4'b0000, 5'b00010, 16'h0001, 16'h0001, 1'b1};
      vecs[9]  = '{"-5+-3=",    4'b0011, 5'b00001, 16'hFFFB, 16'hFFFD, 1'b1};
      vecs[10] = '{"3*-2=",     4'b0010, 5'b01000, 16'h0003, 16'hFFFE, 1'b1};
      vecs[11] = '{"1---2=",    4'b1010, 5'b00000, 16'h0000, 16'h0000, 1'b0};
      vecs[12] = '{"32767+0=",  4'b0000, 5'b00001, 16'h7FFF, 16'h0000, 1'b1};
      vecs[13] = '{"-32769+1=", 4'b0101, 5'b00000, 16'h0000, 16'h0000, 1'b0};
      vecs[14] = '{"32768-1=",  4'b0100, 5'b00000, 16'h0000, 16'h0000, 1'b0};
      vecs[15] = '{" 4 / 2 =",  4'b0000, 5'b10000, 16'h0004, 16'h0002, 1'b1};
      vecs[16] = '{"-0/7=",     4'b0001, 5'b10000, 16'h0000, 16'h0007, 1'b1};
      vecs[17] = '{"5=",        4'b1000, 5'b00000, 16'h0000, 16'h0000, 1'b0};
      vecs[18] = '{"*3=",       4'b1000, 5'b00000, 16'h0000, 16'h0000, 1'b0};
      vecs[19] = '{"-+3=",      4'b1001, 5'b00000, 16'h0000, 16'h0000, 1'b0};

      repeat (3) @(negedge clk);
      chk("reset dtype", 32'(dtype), 32'd0);
      chk("reset operator", 32'(operator), 32'd0);
      chk("reset src1", 32'(src1), 32'd0);
      chk("reset parser_done", 32'(parser_done), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      n_rst = 1'b1;
      repeat (2) @(negedge clk);

      // "12+34\r" with a slow byte rate; pulse must land exactly one cycle after CR
      send_byte(8'h31, 15);
      send_byte(8'h32, 15);
      send_byte(8'h2B, 15);
      send_byte(8'h33, 15);
      send_byte(8'h34, 15);
      p0 = pulse_cnt;
      @(negedge clk);
      rx_data  = 8'h0D;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      chk("cr latency parser_done", 32'(parser_done), 32'd1);
      chk("cr operator", 32'(operator), 32'h01);
      chk("cr src1", 32'(src1), 32'h000C);
      chk("cr src2", 32'(src2), 32'h0022);
      chk("cr dtype", 32'(dtype), 32'd0);
      @(negedge clk);
      chk("cr pulse width", 32'(parser_done), 32'd0);
      chk("cr busy", 32'(busy), 32'd1);
      chk("cr pulse count", 32'(pulse_cnt - p0), 32'd1);
      pulse_alu_done();
      chk("cr busy clear", 32'(busy), 32'd0);

      for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

      // Bytes while busy are dropped, including one coincident with alu_done
      send_text("7+8=");
      repeat (2) @(negedge clk);
      chk("busy entry", 32'(busy), 32'd1);
      p0 = pulse_cnt;
      send_text("9+9=");
      repeat (2) @(negedge clk);
      chk("busy no pulse", 32'(pulse_cnt - p0), 32'd0);
      chk("busy src1 hold", 32'(src1), 32'h0007);
      chk("busy src2 hold", 32'(src2), 32'h0008);
      @(negedge clk);
      alu_done = 1'b1;
      rx_data  = 8'h35;
      rx_valid = 1'b1;
      @(negedge clk);
      alu_done = 1'b0;
      rx_valid = 1'b0;
      chk("alu_done busy clear", 32'(busy), 32'd0);
      send_text("2+2=");
      repeat (2) @(negedge clk);
      chk("after drop src1", 32'(src1), 32'h0002);
      chk("after drop operator", 32'(operator), 32'h01);
      pulse_alu_done();

      // Reset mid-expression
      send_text("12+3");
      @(negedge clk);
      n_rst = 1'b0;
      #1;
      chk("midreset dtype", 32'(dtype), 32'd0);
      chk("midreset operator", 32'(operator), 32'd0);
      chk("midreset src1", 32'(src1), 32'd0);
      chk("midreset src2", 32'(src2), 32'd0);
      chk("midreset busy", 32'(busy), 32'd0);
      @(negedge clk);
      n_rst = 1'b1;
      p0 = pulse_cnt;
      send_text("=");
      repeat (2) @(negedge clk);
      chk("lone terminator no pulse", 32'(pulse_cnt - p0), 32'd0);
      send_text("5/5=");
      repeat (2) @(negedge clk);
      chk("post reset pulses", 32'(pulse_cnt - p0), 32'd1);
      chk("post reset operator", 32'(operator), 32'h10);
      chk("post reset src1", 32'(src1), 32'h0005);
      chk("post reset src2", 32'(src2), 32'h0005);
      chk("post reset busy", 32'(busy), 32'd1);
      pulse_alu_done();

      chk("no back to back pulses", 32'(dbl_cnt), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
